// File: rtl/n_bit_rr_mux_sequencer.sv
// Round-robin select sequencer for an n-bit 4x1 mux: picks a requesting channel,
// drives the mux select, captures the returned data and hands it off via valid/ready.
module n_bit_rr_mux_sequencer #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   REQ,
    input  logic [n-1:0] Y_IN,
    input  logic         READY,
    output logic [1:0]   S,
    output logic [3:0]   GNT,
    output logic [n-1:0] DOUT,
    output logic         VALID,
    output logic [7:0]   XFER_CNT
);

    typedef enum logic [1:0] {StIdle, StSel, StHold} state_e;

    state_e       state_q, state_d;
    logic [1:0]   s_q, s_d;
    logic [1:0]   last_q, last_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [n-1:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [1:0]   pick;
    logic [1:0]   cand;
    logic         found;

    // Scan LAST+1 .. LAST+4 so the most recently served channel has lowest priority.
    always_comb begin
        pick  = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && REQ[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        gnt_d   = 4'b0000;
        dout_d  = dout_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    s_d     = pick;
                    state_d = StSel;
                end
            end
            StSel: begin
                // Capture regardless of whether the chosen request is still up.
                dout_d  = Y_IN;
                gnt_d   = 4'b0001 << s_q;
                valid_d = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (READY) begin
                    valid_d = 1'b0;
                    last_d  = s_q;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= 2'b00;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0000;
            dout_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S        = s_q;
    assign GNT      = gnt_q;
    assign DOUT     = dout_q;
    assign VALID    = valid_q;
    assign XFER_CNT = cnt_q;

endmodule

// File: tb/tb_n_bit_rr_mux_sequencer.sv
// Bench for n_bit_rr_mux_sequencer: transaction-level round-robin model with a
// behavioural 4x1 mux, directed scenarios followed by randomized transfers.
module tb_n_bit_rr_mux_sequencer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   REQ;
    logic [N-1:0] Y_IN;
    logic         READY;
    logic [1:0]   S;
    logic [3:0]   GNT;
    logic [N-1:0] DOUT;
    logic         VALID;
    logic [7:0]   XFER_CNT;

    logic [N-1:0] data [4];
    int           vectors = 0;
    int           errors  = 0;
    int           m_last  = 3;
    int           m_cnt   = 0;

    n_bit_rr_mux_sequencer #(.n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .REQ      (REQ),
        .Y_IN     (Y_IN),
        .READY    (READY),
        .S        (S),
        .GNT      (GNT),
        .DOUT     (DOUT),
        .VALID    (VALID),
        .XFER_CNT (XFER_CNT)
    );

    always #5 clk = ~clk;

    assign Y_IN = data[S];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] req);
        for (int i = 1; i <= 4; i++) begin
            if (req[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transfer starting in IDLE at a negedge; req must be nonzero.
    task automatic xfer(input logic [3:0] req, input int stall, input bit scramble);
        int ch;
        ch    = rr_pick(m_last, req);
        REQ   = req;
        READY = scramble ? 1'($urandom) : 1'b0;
        step();
        check("sel_S", 32'(S), 32'(ch));
        check("sel_valid", 32'(VALID), 32'd0);
        if (scramble) begin
            REQ   = 4'($urandom);
            READY = 1'($urandom);
        end
        step();
        check("cap_dout", 32'(DOUT), 32'(data[ch]));
        check("cap_valid", 32'(VALID), 32'd1);
        check("cap_gnt", 32'(GNT), 32'(4'b0001 << ch));
        for (int k = 0; k < stall; k++) begin
            READY = 1'b0;
            if (scramble) REQ = 4'($urandom);
            step();
            check("hold_valid", 32'(VALID), 32'd1);
            check("hold_dout", 32'(DOUT), 32'(data[ch]));
            check("hold_S", 32'(S), 32'(ch));
            check("hold_gnt", 32'(GNT), 32'd0);
            check("hold_cnt", 32'(XFER_CNT), 32'(m_cnt));
        end
        READY = 1'b1;
        step();
        m_cnt  = (m_cnt + 1) % 256;
        m_last = ch;
        check("hs_valid", 32'(VALID), 32'd0);
        check("hs_gnt", 32'(GNT), 32'd0);
        check("hs_cnt", 32'(XFER_CNT), 32'(m_cnt));
        REQ   = 4'b0000;
        READY = 1'b0;
    endtask

    initial begin
        data[0] = 8'hAA;
        data[1] = 8'h66;
        data[2] = 8'hDD;
        data[3] = 8'h11;
        rst   = 1'b1;
        REQ   = 4'b1111;
        READY = 1'b0;

        // Reset held two cycles with all channels requesting
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_S", 32'(S), 32'd0);
            check("rst_valid", 32'(VALID), 32'd0);
            check("rst_dout", 32'(DOUT), 32'd0);
            check("rst_cnt", 32'(XFER_CNT), 32'd0);
            check("rst_gnt", 32'(GNT), 32'd0);
        end
        rst = 1'b0;
        REQ = 4'b0000;

        // No requests: S holds, nothing captured
        for (int k = 0; k < 3; k++) begin
            READY = 1'($urandom);
            step();
            check("idle_S", 32'(S), 32'd0);
            check("idle_valid", 32'(VALID), 32'd0);
        end
        READY = 1'b0;

        // Single channel C
        xfer(4'b0100, 0, 1'b0);

        // All requesting: 12 transfers rotate through channels
        for (int t = 0; t < 12; t++) xfer(4'b1111, 0, 1'b0);

        // Backpressure on channel B for 10 cycles
        xfer(4'b0010, 10, 1'b0);

        // Skip: A and D requesting after B -> D, A, D
        check("skip_model", 32'(rr_pick(m_last, 4'b1001)), 32'd3);
        for (int t = 0; t < 3; t++) xfer(4'b1001, 0, 1'b0);

        // Reset while VALID is held
        REQ = 4'b0010;
        step();
        step();
        check("mid_valid", 32'(VALID), 32'd1);
        rst = 1'b1;
        REQ = 4'b0000;
        step();
        rst    = 1'b0;
        m_last = 3;
        m_cnt  = 0;
        check("mid_rst_valid", 32'(VALID), 32'd0);
        check("mid_rst_cnt", 32'(XFER_CNT), 32'd0);
        check("mid_rst_dout", 32'(DOUT), 32'd0);
        check("mid_rst_S", 32'(S), 32'd0);

        // 256 randomized transfers: counter must wrap back to 0
        for (int t = 0; t < 256; t++) begin
            logic [3:0] r;
            for (int c = 0; c < 4; c++) data[c] = N'($urandom);
            r = 4'($urandom_range(1, 15));
            xfer(r, int'($urandom_range(0, 3)), 1'b1);
        end
        check("wrap_cnt", 32'(XFER_CNT), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
